// File: rtl/nic_pkg.sv
// Shared packet-field positions and register-map addresses for the ring NIC.
package nic_pkg;

  localparam int unsigned VC_BIT   = 63;
  localparam int unsigned DIR_BIT  = 30;
  localparam int unsigned HOP_MSB  = 25;
  localparam int unsigned HOP_LSB  = 18;
  localparam int unsigned SRC_MSB  = 15;
  localparam int unsigned SRC_LSB  = 0;

  // Position of the optional statistics counter in a status read.
  localparam int unsigned STAT_MSB = 47;
  localparam int unsigned STAT_LSB = 32;

  typedef enum logic [1:0] {
    ADDR_RX_DATA = 2'b00,
    ADDR_RX_STAT = 2'b01,
    ADDR_TX_DATA = 2'b10,
    ADDR_TX_STAT = 2'b11
  } nic_addr_e;

endpackage

// File: rtl/nic_fifo.sv
// Circular packet FIFO; push into a full FIFO and pop from an empty one are ignored.
module nic_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PKT_W = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [PKT_W-1:0]       din,
  output logic [PKT_W-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PKT_W-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ring_nic.sv
// Processor <-> ring-router PE network interface with polarity-gated injection.
// Define NIC_STATS_EN to add tx_sent/rx_recv counters reported in status reads.
module ring_nic
  import nic_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PKT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic [PKT_W-1:0] d_in,
  output logic [PKT_W-1:0] d_out,
  input  logic             nicEn,
  input  logic             nicWrEn,
  input  logic             net_si,
  output logic             net_ri,
  input  logic [PKT_W-1:0] net_di,
  output logic             net_so,
  input  logic             net_ro,
  output logic [PKT_W-1:0] net_do,
  input  logic             net_polarity
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PKT_W-1:0] rx_head, tx_head;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic [CNT_W-1:0] rx_count, tx_count;
  logic             rx_rd, tx_wr;
  logic [PKT_W-1:0] d_out_q, d_out_d;
  logic             tx_drop_q, tx_drop_d;
  logic             unused_flags;

  assign rx_rd  = nicEn & ~nicWrEn & (addr == ADDR_RX_DATA);
  assign tx_wr  = nicEn &  nicWrEn & (addr == ADDR_TX_DATA);
  assign net_ri = (rx_count != CNT_W'(DEPTH));
  assign net_so = ~tx_empty & net_ro & (tx_head[VC_BIT] == net_polarity);
  assign net_do = tx_empty ? '0 : tx_head;
  assign d_out  = d_out_q;
  assign unused_flags = rx_full ^ (^tx_count);

  nic_fifo #(.DEPTH(DEPTH), .PKT_W(PKT_W)) u_rx (
    .clk   (clk),
    .reset (reset),
    .push  (net_si & net_ri),
    .pop   (rx_rd),
    .din   (net_di),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // tx fullness is sampled before the edge, so a same-cycle router pop never frees room for a write.
  nic_fifo #(.DEPTH(DEPTH), .PKT_W(PKT_W)) u_tx (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr & ~tx_full),
    .pop   (net_so),
    .din   (d_in),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

`ifdef NIC_STATS_EN
  logic [15:0] tx_sent_q, tx_sent_d;
  logic [15:0] rx_recv_q, rx_recv_d;

  always_comb begin
    tx_sent_d = tx_sent_q + {15'b0, net_so};
    rx_recv_d = rx_recv_q + {15'b0, net_si & net_ri};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sent_q <= '0;
      rx_recv_q <= '0;
    end else begin
      tx_sent_q <= tx_sent_d;
      rx_recv_q <= rx_recv_d;
    end
  end
`endif

  always_comb begin
    d_out_d   = d_out_q;
    tx_drop_d = tx_drop_q;
    if (nicEn && !nicWrEn) begin
      d_out_d = '0;
      case (addr)
        ADDR_RX_DATA: if (!rx_empty) d_out_d = rx_head;
        ADDR_RX_STAT: begin
          d_out_d[0] = ~rx_empty;
`ifdef NIC_STATS_EN
          d_out_d[STAT_MSB:STAT_LSB] = rx_recv_q;
`endif
        end
        ADDR_TX_STAT: begin
          d_out_d[1:0] = {tx_drop_q, tx_full};
          tx_drop_d    = 1'b0;
`ifdef NIC_STATS_EN
          d_out_d[STAT_MSB:STAT_LSB] = tx_sent_q;
`endif
        end
        default: ;
      endcase
    end
    if (tx_wr && tx_full) tx_drop_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out_q   <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      d_out_q   <= d_out_d;
      tx_drop_q <= tx_drop_d;
    end
  end

endmodule

// File: tb/tb_ring_nic.sv
// Self-checking bench for ring_nic: directed scenarios plus randomized traffic against a queue model.
module tb_ring_nic;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic [63:0] d_in = '0;
  logic [63:0] d_out;
  logic        nicEn = 1'b0, nicWrEn = 1'b0;
  logic        net_si = 1'b0, net_ri;
  logic [63:0] net_di = '0;
  logic        net_so;
  logic        net_ro = 1'b0;
  logic [63:0] net_do;
  logic        net_polarity = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_nic #(.DEPTH(DEPTH), .PKT_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  task automatic drive(input logic en, input logic wr, input logic [1:0] a, input logic [63:0] din,
                       input logic si, input logic [63:0] di, input logic ro, input logic pol);
    nicEn = en; nicWrEn = wr; addr = a; d_in = din;
    net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 2'b00, '0, 0, '0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [63:0] rnd_pkt(input logic vc);
    logic [63:0] p;
    p = {$urandom, $urandom};
    p[63] = vc;
    return p;
  endfunction

  task automatic test_reset();
    do_reset();
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri: got %b expected 1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", net_so); end
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    drive(1, 1, 2'b10, rnd_pkt(0), 1, rnd_pkt(1), 0, 0);
    step();
    drive(1, 0, 2'b01, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL pre_reset_stat: got %h expected 1", d_out); end
    drive(0, 0, 2'b00, '0, 0, '0, 1, 0);
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL pre_reset_so: got %b expected 1", net_so); end
    #1 reset = 1'b1;
    #1;
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL midreset_ri: got %b expected 1", net_ri); end
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL midreset_so: got %b expected 0", net_so); end
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL midreset_dout: got %h expected 0", d_out); end
    checks++; if (net_do !== 64'h0) begin errors++; $display("FAIL midreset_do: got %h expected 0", net_do); end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1, 0, 2'b01, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL post_reset_rxstat: got %h expected 0", d_out); end
    drive(1, 0, 2'b11, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL post_reset_txstat: got %h expected 0", d_out); end
  endtask

  task automatic test_polarity();
    logic [63:0] p;
    p = 64'h8000_0000_4000_0001;
    do_reset();
    drive(1, 1, 2'b10, p, 0, '0, 1, 0);
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_empty_so: got %b expected 0", net_so); end
    step();
    drive(0, 0, 2'b00, '0, 0, '0, 1, 0);
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_even_so: got %b expected 0", net_so); end
    checks++; if (net_do !== p) begin errors++; $display("FAIL pol_even_do: got %h expected %h", net_do, p); end
    drive(0, 0, 2'b00, '0, 0, '0, 0, 1);
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_noro_so: got %b expected 0", net_so); end
    step();
    drive(0, 0, 2'b00, '0, 0, '0, 1, 1);
    checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL pol_odd_so: got %b expected 1", net_so); end
    checks++; if (net_do !== p) begin errors++; $display("FAIL pol_odd_do: got %h expected %h", net_do, p); end
    step();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_after_so: got %b expected 0", net_so); end
    checks++; if (net_do !== 64'h0) begin errors++; $display("FAIL pol_after_do: got %h expected 0", net_do); end
  endtask

  task automatic test_tx_drop();
    logic [63:0] t [3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      t[i] = rnd_pkt(0);
      drive(1, 1, 2'b10, t[i], 0, '0, 0, 0);
      step();
    end
    drive(1, 0, 2'b11, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== 64'h3) begin errors++; $display("FAIL drop_stat1: got %h expected 3", d_out); end
    step();
    checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL drop_stat2: got %h expected 1", d_out); end
    drive(0, 0, 2'b00, '0, 0, '0, 1, 0);
    checks++; if (net_do !== t[0]) begin errors++; $display("FAIL drop_head0: got %h expected %h", net_do, t[0]); end
    step();
    checks++; if (net_do !== t[1]) begin errors++; $display("FAIL drop_head1: got %h expected %h", net_do, t[1]); end
    step();
    checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL drop_drained_so: got %b expected 0", net_so); end
    for (int i = 0; i < 2; i++) begin
      t[i] = rnd_pkt(0);
      drive(1, 1, 2'b10, t[i], 0, '0, 0, 0);
      step();
    end
    t[2] = rnd_pkt(0);
    drive(1, 1, 2'b10, t[2], 0, '0, 1, 0);
    step();
    drive(1, 0, 2'b11, '0, 0, '0, 0, 0);
    checks++; if (net_do !== t[1]) begin errors++; $display("FAIL simul_head: got %h expected %h", net_do, t[1]); end
    step();
    checks++; if (d_out !== 64'h2) begin errors++; $display("FAIL simul_drop_stat: got %h expected 2", d_out); end
  endtask

  task automatic test_rx_path();
    logic [63:0] a, b, x, c, d;
    a = rnd_pkt(0); b = rnd_pkt(1); x = rnd_pkt(1); c = rnd_pkt(0); d = rnd_pkt(1);
    do_reset();
    drive(0, 0, 2'b00, '0, 1, a, 0, 0);
    step();
    drive(0, 0, 2'b00, '0, 1, b, 0, 0);
    step();
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_full_ri: got %b expected 0", net_ri); end
    drive(0, 0, 2'b00, '0, 1, x, 0, 0);
    step();
    drive(1, 0, 2'b00, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== a) begin errors++; $display("FAIL rx_read_a: got %h expected %h", d_out, a); end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_after_pop_ri: got %b expected 1", net_ri); end
    drive(1, 0, 2'b00, '0, 1, c, 0, 0);
    step();
    checks++; if (d_out !== b) begin errors++; $display("FAIL rx_simul_b: got %h expected %h", d_out, b); end
    checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL rx_simul_ri: got %b expected 1", net_ri); end
    drive(0, 0, 2'b00, '0, 1, d, 0, 0);
    step();
    checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL rx_refill_ri: got %b expected 0", net_ri); end
    drive(1, 0, 2'b00, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== c) begin errors++; $display("FAIL rx_read_c: got %h expected %h", d_out, c); end
    step();
    checks++; if (d_out !== d) begin errors++; $display("FAIL rx_read_d: got %h expected %h", d_out, d); end
    drive(0, 0, 2'b00, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== d) begin errors++; $display("FAIL rx_hold: got %h expected %h", d_out, d); end
  endtask

  task automatic test_rx_empty();
    logic [63:0] d, e;
    d = rnd_pkt(1); e = rnd_pkt(0);
    do_reset();
    drive(0, 0, 2'b00, '0, 1, d, 0, 0);
    step();
    drive(1, 0, 2'b00, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== d) begin errors++; $display("FAIL empty_first: got %h expected %h", d_out, d); end
    step();
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL empty_read: got %h expected 0", d_out); end
    drive(1, 0, 2'b01, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL empty_stat: got %h expected 0", d_out); end
    drive(0, 0, 2'b00, '0, 1, e, 0, 0);
    step();
    drive(1, 0, 2'b00, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== e) begin errors++; $display("FAIL empty_then_push: got %h expected %h", d_out, e); end
  endtask

  task automatic test_stats();
    logic [63:0] exp_tx, exp_rx;
`ifdef NIC_STATS_EN
    exp_tx = 64'd3 << 32;
    exp_rx = (64'd2 << 32) | 64'h1;
`else
    exp_tx = 64'h0;
    exp_rx = 64'h1;
`endif
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'b10, rnd_pkt(0), 0, '0, 0, 0);
      step();
      drive(0, 0, 2'b00, '0, 0, '0, 1, 0);
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 2'b00, '0, 1, rnd_pkt(1), 0, 0);
      step();
    end
    drive(1, 0, 2'b11, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== exp_tx) begin errors++; $display("FAIL stats_tx: got %h expected %h", d_out, exp_tx); end
    drive(1, 0, 2'b01, '0, 0, '0, 0, 0);
    step();
    checks++; if (d_out !== exp_rx) begin errors++; $display("FAIL stats_rx: got %h expected %h", d_out, exp_rx); end
  endtask

  task automatic test_random();
    logic [63:0] m_rx[$];
    logic [63:0] m_tx[$];
    logic        m_drop;
    logic [63:0] m_dout;
    logic [15:0] m_sent, m_recv;
    logic        en, wr, si, ro, pol, exp_ri, exp_so, t_full;
    logic [1:0]  a;
    logic [63:0] din, di, exp_do, sent_f, recv_f;
    do_reset();
    m_drop = 1'b0; m_dout = '0; m_sent = '0; m_recv = '0;
    for (int n = 0; n < 400; n++) begin
      en  = ($urandom_range(0, 3) != 0);
      wr  = $urandom_range(0, 1);
      a   = 2'($urandom_range(0, 3));
      din = rnd_pkt($urandom_range(0, 1));
      si  = $urandom_range(0, 1);
      di  = rnd_pkt($urandom_range(0, 1));
      ro  = ($urandom_range(0, 3) != 0);
      pol = $urandom_range(0, 1);
      drive(en, wr, a, din, si, di, ro, pol);
      exp_ri = (m_rx.size() != DEPTH);
      exp_so = (m_tx.size() != 0) && ro && (m_tx[0][63] == pol);
      exp_do = (m_tx.size() != 0) ? m_tx[0] : 64'h0;
      t_full = (m_tx.size() == DEPTH);
      checks++; if (net_ri !== exp_ri) begin errors++; $display("FAIL rand_ri[%0d]: got %b expected %b", n, net_ri, exp_ri); end
      checks++; if (net_so !== exp_so) begin errors++; $display("FAIL rand_so[%0d]: got %b expected %b", n, net_so, exp_so); end
      checks++; if (net_do !== exp_do) begin errors++; $display("FAIL rand_do[%0d]: got %h expected %h", n, net_do, exp_do); end
`ifdef NIC_STATS_EN
      sent_f = {16'h0, m_sent, 32'h0};
      recv_f = {16'h0, m_recv, 32'h0};
`else
      sent_f = '0;
      recv_f = '0;
`endif
      if (en && !wr) begin
        case (a)
          2'b00: m_dout = (m_rx.size() != 0) ? m_rx[0] : 64'h0;
          2'b01: m_dout = recv_f | {63'h0, m_rx.size() != 0};
          2'b10: m_dout = 64'h0;
          default: begin
            m_dout = sent_f | {62'h0, m_drop, t_full};
            m_drop = 1'b0;
          end
        endcase
        if (a == 2'b00 && m_rx.size() != 0) void'(m_rx.pop_front());
      end
      if (exp_so) void'(m_tx.pop_front());
      if (en && wr && a == 2'b10) begin
        if (t_full) m_drop = 1'b1;
        else m_tx.push_back(din);
      end
      if (si && exp_ri) m_rx.push_back(di);
      m_sent = m_sent + 16'(exp_so);
      m_recv = m_recv + 16'(si && exp_ri);
      step();
      checks++; if (d_out !== m_dout) begin errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", n, d_out, m_dout); end
    end
  endtask

  initial begin
    test_reset();
    test_polarity();
    test_tx_drop();
    test_rx_path();
    test_rx_empty();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
